// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, flag bundle, control states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_t;

  // Packs as {Z,N,C,V}, matching the 4-bit flags port.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Issue/writeback handshake bundle for alu_mc.
interface alu_mc_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  alu_flags_t       flags;
  logic             err;

  // Issue stage / writeback side.
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags, err
  );

  // ALU side.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags, err
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done is combinational in the final iteration and product is the
// accumulator value that iteration produces, so the caller can register the
// result on the same edge that retires the last partial product.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign done    = busy && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;

  // Operand load on start, then one shift-add step per cycle while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle datapath for logic/arith/shift/compare ops,
// iterative multiplier for OP_MUL, registered result/flags/err held until
// the consumer takes them. One operation in flight at a time.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  alu_state_t       state, state_nxt;
  alu_op_t          op_c;
  logic [SW-1:0]    sh;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] res_c;
  alu_flags_t       flg_c;
  logic             err_c;
  logic             mul_op;
  logic             mul_go;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign op_c   = alu_op_t'(bus.op);
  assign sh     = bus.b[SW-1:0];
  assign add_w  = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_w  = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
  assign mul_op = (op_c == OP_MUL) && MUL_EN;
  assign mul_go = (state == IDLE) && bus.in_valid && mul_op;

  // Single-cycle datapath and flags; anything unrecognised (or MUL when the
  // multiplier is not built) reports err with zero result and zero flags.
  always_comb begin
    res_c = '0;
    flg_c = '0;
    err_c = 1'b0;
    case (op_c)
      OP_ADD: begin
        res_c   = add_w[WIDTH-1:0];
        flg_c.c = add_w[WIDTH];
        flg_c.v = (bus.a[M] == bus.b[M]) && (add_w[M] != bus.a[M]);
      end
      OP_SUB: begin
        res_c   = sub_w[WIDTH-1:0];
        flg_c.c = sub_w[WIDTH];
        flg_c.v = (bus.a[M] != bus.b[M]) && (sub_w[M] != bus.a[M]);
      end
      OP_AND:  res_c = bus.a & bus.b;
      OP_OR:   res_c = bus.a | bus.b;
      OP_XOR:  res_c = bus.a ^ bus.b;
      OP_SLT:  res_c = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLTU: res_c = WIDTH'(bus.a < bus.b);
      OP_SLL:  res_c = bus.a << sh;
      OP_SRL:  res_c = bus.a >> sh;
      OP_SRA:  res_c = WIDTH'($signed(bus.a) >>> sh);
      OP_MUL:  err_c = !MUL_EN;
      default: err_c = 1'b1;
    endcase
    if (!err_c) begin
      flg_c.z = (res_c == '0);
      flg_c.n = res_c[M];
    end
  end

  if (MUL_EN) begin : g_mul
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_go),
      .a       (bus.a),
      .b       (bus.b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
    );
  end else begin : g_nomul
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: accept in IDLE, iterate in MUL, hold in DONE until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = mul_op ? MUL : DONE;
      MUL:  if (mul_done)     state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers: loaded on a single-cycle accept or on the last
  // multiplier step, otherwise held so DONE presents a stable result.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result <= '0;
      bus.flags  <= '0;
      bus.err    <= 1'b0;
    end else if ((state == IDLE) && bus.in_valid && !mul_op) begin
      bus.result <= res_c;
      bus.flags  <= flg_c;
      bus.err    <= err_c;
    end else if ((state == MUL) && mul_done) begin
      bus.result <= mul_prod;
      bus.flags  <= '{z: (mul_prod == '0), n: mul_prod[M], c: 1'b0, v: 1'b0};
      bus.err    <= 1'b0;
    end
  end

  assign bus.in_ready  = (state == IDLE) && !mul_busy;
  assign bus.out_valid = (state == DONE);
endmodule
